// File: rtl/tea_pkg.sv
// ---------------------------------------------------------------------------
// tea_pkg
// Shared types, constants and helpers for the iterative TEA engine.
//   DELTA       : TEA key-schedule constant
//   word_t      : 32-bit TEA word
//   tea_state_t : engine state (IDLE, RUN, DONE)
//   byteswap32 / swap64 / swap128 : per-32-bit-word byte reversal
//   tea_f       : TEA mixing function F(x,a,b,s)
// ---------------------------------------------------------------------------
package tea_pkg;

   localparam logic [31:0] DELTA = 32'h9E3779B9;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } tea_state_t;

   // Reverse the byte order of one 32-bit word (little-endian host words).
   function automatic word_t byteswap32(input word_t w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Byte-swap each 32-bit word of a 64-bit value, word positions unchanged.
   function automatic logic [63:0] swap64(input logic [63:0] d);
      return {byteswap32(d[63:32]), byteswap32(d[31:0])};
   endfunction

   // Byte-swap each 32-bit word of a 128-bit key, word positions unchanged.
   function automatic logic [127:0] swap128(input logic [127:0] d);
      return {swap64(d[127:64]), swap64(d[63:0])};
   endfunction

   // TEA mixing function; all arithmetic wraps mod 2^32, >> is logical.
   function automatic word_t tea_f(input word_t x, input word_t a, input word_t b, input word_t s);
      return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
   endfunction

endpackage

// File: rtl/tea_iter_core_if.sv
// ---------------------------------------------------------------------------
// tea_iter_core_if
// Bundles the key-load, input-block, output-block and status signals of the
// TEA engine.
//   master : host / stream side (drives key, input block and out_ready)
//   slave  : the engine (drives key_valid, in_ready, out_valid, out_data, busy)
// ---------------------------------------------------------------------------
interface tea_iter_core_if;

   logic        key_wr;
   logic        key_sel;
   logic [63:0] key_in;
   logic        key_valid;

   logic        in_valid;
   logic        in_ready;
   logic        in_mode;
   logic [63:0] in_data;

   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;

   logic        busy;

   modport master (
      output key_wr, key_sel, key_in, in_valid, in_mode, in_data, out_ready,
      input  key_valid, in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  key_wr, key_sel, key_in, in_valid, in_mode, in_data, out_ready,
      output key_valid, in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/tea_cycle.sv
// ---------------------------------------------------------------------------
// tea_cycle
// Combinational single TEA cycle (two half-rounds), encrypt or decrypt.
//   v_i    : {v0,v1} before the cycle        v_o   : {v0,v1} after the cycle
//   key_i  : {k0,k1,k2,k3}, k0 = [127:96]    sum_i : running sum before
//   mode_i : 0 encrypt, 1 decrypt            sum_o : running sum after
// ---------------------------------------------------------------------------
module tea_cycle
   import tea_pkg::*;
(
   input  logic [63:0]  v_i,
   input  logic [127:0] key_i,
   input  word_t        sum_i,
   input  logic         mode_i,
   output logic [63:0]  v_o,
   output word_t        sum_o
);

   word_t k0, k1, k2, k3;
   word_t v0, v1;
   word_t n0, n1, sumN;

   assign k0 = key_i[127:96];
   assign k1 = key_i[95:64];
   assign k2 = key_i[63:32];
   assign k3 = key_i[31:0];
   assign v0 = v_i[63:32];
   assign v1 = v_i[31:0];

   // Encrypt advances the sum first and updates v0 then v1; decrypt undoes
   // this exactly, so it mixes v1 then v0 with the current sum and steps the
   // sum back afterwards.
   always_comb begin
      sumN = '0;
      n0   = '0;
      n1   = '0;
      if (!mode_i) begin
         sumN = sum_i + DELTA;
         n0   = v0 + tea_f(v1, k0, k1, sumN);
         n1   = v1 + tea_f(n0, k2, k3, sumN);
      end else begin
         n1   = v1 - tea_f(v0, k2, k3, sum_i);
         n0   = v0 - tea_f(n1, k0, k1, sum_i);
         sumN = sum_i - DELTA;
      end
   end

   assign v_o   = {n0, n1};
   assign sum_o = sumN;

endmodule

// File: rtl/tea_iter_core.sv
// ---------------------------------------------------------------------------
// tea_iter_core
// Iterative TEA encrypt/decrypt engine, UNROLL cycles per clock, one block in
// flight at a time.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : tea_iter_core_if.slave
//                key_wr/key_sel/key_in -> 64-bit key half writes (IDLE only)
//                key_valid             -> both halves written since reset
//                in_valid/in_ready     -> block accept, in_mode/in_data sampled
//                out_valid/out_ready   -> result held until taken
//                busy                  -> engine not IDLE
// Parameters: ROUNDS (1..64, multiple of UNROLL), UNROLL, SWAP_BYTES.
// ---------------------------------------------------------------------------
module tea_iter_core
   import tea_pkg::*;
#(
   parameter int ROUNDS     = 32,
   parameter int UNROLL     = 1,
   parameter bit SWAP_BYTES = 1'b1
) (
   input logic        clk,
   input logic        rst_n,
   tea_iter_core_if.slave bus
);

   if ((ROUNDS < 1) || (ROUNDS > 64) || (UNROLL < 1) || ((ROUNDS % UNROLL) != 0)) begin : g_bad_params
      $error("tea_iter_core: ROUNDS must be 1..64 and a multiple of UNROLL");
   end

   localparam int STEPS = ROUNDS / UNROLL;
   localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
   localparam logic [63:0] DEC_PROD = 64'(ROUNDS) * 64'(DELTA);
   localparam word_t DEC_SUM = DEC_PROD[31:0];

   // Host words arrive little-endian when SWAP_BYTES is set.
   function automatic logic [63:0] host64(input logic [63:0] d);
      return SWAP_BYTES ? swap64(d) : d;
   endfunction

   tea_state_t   state_q;
   logic [63:0]  v_q;
   word_t        sum_q;
   logic         mode_q;
   logic [CW-1:0] cnt_q;
   logic [127:0] key_q;
   logic         hiWritten_q;
   logic         loWritten_q;
   logic         outValid_q;
   logic [63:0]  outData_q;

   logic         keyValid;
   logic         inReady;
   logic [63:0]  v_d;
   word_t        sum_d;

   logic [63:0]  vChain [UNROLL+1];
   word_t        sumChain [UNROLL+1];

   assign keyValid = hiWritten_q && loWritten_q;
   assign inReady  = (state_q == IDLE) && keyValid;

   // The key register already holds the byte-swapped key, so the chain uses
   // it directly; each stage feeds the next within the same clock.
   assign vChain[0]   = v_q;
   assign sumChain[0] = sum_q;

   for (genvar i = 0; i < UNROLL; i++) begin : g_chain
      tea_cycle u_cycle (
         .v_i    (vChain[i]),
         .key_i  (key_q),
         .sum_i  (sumChain[i]),
         .mode_i (mode_q),
         .v_o    (vChain[i+1]),
         .sum_o  (sumChain[i+1])
      );
   end

   assign v_d   = vChain[UNROLL];
   assign sum_d = sumChain[UNROLL];

   // Single FSM block. Key writes are honoured only in IDLE so the key stays
   // fixed for the whole block; a write on the accept edge is visible to the
   // first RUN clock because the chain reads key_q after that edge. The
   // result is captured on the same edge as the last round update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         v_q         <= '0;
         sum_q       <= '0;
         mode_q      <= 1'b0;
         cnt_q       <= '0;
         key_q       <= '0;
         hiWritten_q <= 1'b0;
         loWritten_q <= 1'b0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.key_wr) begin
                  if (bus.key_sel) begin
                     key_q[63:0] <= host64(bus.key_in);
                     loWritten_q <= 1'b1;
                  end else begin
                     key_q[127:64] <= host64(bus.key_in);
                     hiWritten_q   <= 1'b1;
                  end
               end
               if (bus.in_valid && inReady) begin
                  v_q     <= host64(bus.in_data);
                  mode_q  <= bus.in_mode;
                  cnt_q   <= '0;
                  sum_q   <= bus.in_mode ? DEC_SUM : '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               v_q   <= v_d;
               sum_q <= sum_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q    <= DONE;
                  outValid_q <= 1'b1;
                  outData_q  <= host64(v_d);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q    <= IDLE;
                  outValid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.key_valid = keyValid;
   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid_q;
   assign bus.out_data  = outData_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tea_iter_core.sv
// ---------------------------------------------------------------------------
// tb_tea_iter_core
// Self-checking bench for tea_iter_core (ROUNDS=32, UNROLL=2, SWAP_BYTES=1).
// A cycle-level reference built from plain TEA arithmetic predicts every
// output on each falling edge; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_tea_iter_core;

   localparam int ROUNDS = 32;
   localparam int UNROLL = 2;
   localparam int STEPS  = ROUNDS / UNROLL;
   localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;
   localparam logic [63:0] VEC_ZERO_RAW  = 64'h41EA3A0A_94BAA940;
   localparam logic [63:0] VEC_ZERO_HOST = 64'h0A3AEA41_40A9BA94;

   logic clk;
   logic rst_n;

   int nChecks = 0;
   int nFails  = 0;

   tea_iter_core_if bus();

   tea_iter_core #(
      .ROUNDS     (ROUNDS),
      .UNROLL     (UNROLL),
      .SWAP_BYTES (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference TEA on plain words.
   function automatic logic [63:0] teaModel(input logic [63:0] blk, input logic [127:0] key, input bit dec);
      logic [31:0] y, z, s, k0, k1, k2, k3;
      y  = blk[63:32];
      z  = blk[31:0];
      k0 = key[127:96];
      k1 = key[95:64];
      k2 = key[63:32];
      k3 = key[31:0];
      if (!dec) begin
         s = 32'd0;
         for (int r = 0; r < ROUNDS; r++) begin
            s = s + TEA_DELTA;
            y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
         end
      end else begin
         s = TEA_DELTA * 32'(ROUNDS);
         for (int r = 0; r < ROUNDS; r++) begin
            z = z - (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
            y = y - (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            s = s - TEA_DELTA;
         end
      end
      return {y, z};
   endfunction

   function automatic logic [31:0] bs32(input logic [31:0] w);
      logic [31:0] r;
      r = {<<8{w}};
      return r;
   endfunction

   function automatic logic [63:0] bs64(input logic [63:0] d);
      return {bs32(d[63:32]), bs32(d[31:0])};
   endfunction

   // Host-view result: little-endian words in and out, key written as raw halves.
   function automatic logic [63:0] hostModel(input logic [63:0] blk, input logic [127:0] keyRaw, input bit dec);
      return bs64(teaModel(bs64(blk), {bs64(keyRaw[127:64]), bs64(keyRaw[63:0])}, dec));
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-level reference state.
   logic [127:0] mKey;
   bit           mHi, mLo;
   int           mRemain;
   bit           mHolding;
   logic [63:0]  mOutData;
   logic [63:0]  mPending;

   // Compare process: check all outputs on the falling edge, then advance the
   // reference by what the next rising edge will do with the current inputs.
   always @(negedge clk) begin
      if (!rst_n) begin
         mKey = '0; mHi = 0; mLo = 0; mRemain = 0; mHolding = 0;
         mOutData = '0; mPending = '0;
         checkOutput("rst_keyValid", bus.key_valid, 0);
         checkOutput("rst_outValid", bus.out_valid, 0);
         checkOutput("rst_busy", bus.busy, 0);
         checkOutput("rst_outData", bus.out_data, 64'd0);
      end else begin
         automatic bit kv = mHi && mLo;
         automatic bit idle = (mRemain == 0) && !mHolding;
         checkOutput("cyc_keyValid", bus.key_valid, kv);
         checkOutput("cyc_inReady", bus.in_ready, idle && kv);
         checkOutput("cyc_busy", bus.busy, !idle);
         checkOutput("cyc_outValid", bus.out_valid, mHolding);
         checkOutput("cyc_outData", bus.out_data, mOutData);
         if (mHolding) begin
            if (bus.out_ready) mHolding = 0;
         end else if (mRemain > 0) begin
            mRemain--;
            if (mRemain == 0) begin
               mHolding = 1;
               mOutData = mPending;
            end
         end else begin
            if (bus.key_wr) begin
               if (bus.key_sel) begin mKey[63:0] = bus.key_in; mLo = 1; end
               else begin mKey[127:64] = bus.key_in; mHi = 1; end
            end
            if (bus.in_valid && kv) begin
               mRemain  = STEPS;
               mPending = hostModel(bus.in_data, mKey, bus.in_mode);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeKey(input logic sel, input logic [63:0] val);
      bus.key_sel = sel;
      bus.key_in  = val;
      bus.key_wr  = 1'b1;
      tick();
      bus.key_wr  = 1'b0;
   endtask

   // Send one block, optionally try a key write during RUN, wait for the
   // result, hold it off for 'gap' clocks, then take it.
   task automatic applyStimulus(input logic [63:0] data, input logic mode, input bit injectKey,
                                input int gap, output logic [63:0] result, output int latency);
      bit acc;
      int n;
      bus.in_data  = data;
      bus.in_mode  = mode;
      bus.in_valid = 1'b1;
      acc = 0;
      n = 0;
      while (!acc && n < 200) begin
         acc = bus.in_ready;
         tick();
         n++;
      end
      bus.in_valid = 1'b0;
      checkOutput("acceptWithinBound", acc, 1);
      latency = 0;
      if (injectKey) begin
         bus.key_sel = 1'b0;
         bus.key_in  = 64'hFFFF_0000_A5A5_5A5A;
         bus.key_wr  = 1'b1;
         tick();
         bus.key_wr  = 1'b0;
         latency = 1;
      end
      while (!bus.out_valid && latency < 200) begin
         tick();
         latency++;
      end
      repeat (gap) tick();
      result = bus.out_data;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] res, d, c, p;
      int lat;
      bit m;

      rst_n         = 1'b0;
      bus.key_wr    = 1'b0;
      bus.key_sel   = 1'b0;
      bus.key_in    = '0;
      bus.in_valid  = 1'b0;
      bus.in_mode   = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Pin the reference against the published all-zero TEA vector.
      checkOutput("modelEncPin", teaModel(64'd0, 128'd0, 0), VEC_ZERO_RAW);
      checkOutput("modelDecPin", teaModel(VEC_ZERO_RAW, 128'd0, 1), 64'd0);

      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] block held off until the key is loaded, zero-key vector");
      bus.in_data  = '0;
      bus.in_mode  = 1'b0;
      bus.in_valid = 1'b1;
      repeat (3) tick();
      checkOutput("inReadyNoKey", bus.in_ready, 0);
      writeKey(1'b0, 64'd0);
      checkOutput("inReadyHalfKey", bus.in_ready, 0);
      writeKey(1'b1, 64'd0);
      checkOutput("inReadyKeyed", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         tick();
         lat++;
      end
      checkOutput("latencyVector", 64'(lat), 64'(STEPS));
      for (int i = 0; i < 10; i++) begin
         checkOutput("holdOutData", bus.out_data, VEC_ZERO_HOST);
         checkOutput("holdOutValid", bus.out_valid, 1);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checkOutput("inReadyAfterTake", bus.in_ready, 1);
      checkOutput("busyAfterTake", bus.busy, 0);

      $display("[TB] key write during RUN is ignored");
      applyStimulus(64'd0, 1'b0, 1'b1, 2, res, lat);
      checkOutput("keyIgnoredInRun", res, VEC_ZERO_HOST);
      writeKey(1'b0, 64'h1111_2222_3333_4444);
      applyStimulus(64'd0, 1'b0, 1'b0, 0, res, lat);
      checkOutput("newKeyUsed", res, hostModel(64'd0, {64'h1111_2222_3333_4444, 64'd0}, 0));

      $display("[TB] round trip with fixed key");
      writeKey(1'b0, 64'h01234567_89ABCDEF);
      writeKey(1'b1, 64'hFEDCBA98_76543210);
      for (int i = 0; i < 16; i++) begin
         d = {$urandom, $urandom};
         applyStimulus(d, 1'b0, 1'b0, $urandom_range(0, 3), c, lat);
         checkOutput("latencyEnc", 64'(lat), 64'(STEPS));
         applyStimulus(c, 1'b1, 1'b0, $urandom_range(0, 3), p, lat);
         checkOutput("latencyDec", 64'(lat), 64'(STEPS));
         checkOutput("roundTrip", p, d);
      end

      $display("[TB] random blocks, modes, key rewrites and ready gaps");
      for (int b = 0; b < 1000; b++) begin
         if ($urandom_range(0, 7) == 0) writeKey(1'($urandom_range(0, 1)), {$urandom, $urandom});
         repeat ($urandom_range(0, 2)) tick();
         d = {$urandom, $urandom};
         m = 1'($urandom_range(0, 1));
         applyStimulus(d, m, 1'b0, $urandom_range(0, 4), res, lat);
      end

      $display("[TB] asynchronous reset in the middle of a block");
      bus.in_data  = {$urandom, $urandom};
      bus.in_mode  = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      checkOutput("busyBeforeReset", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncRstOutValid", bus.out_valid, 0);
      checkOutput("asyncRstBusy", bus.busy, 0);
      checkOutput("asyncRstKeyValid", bus.key_valid, 0);
      checkOutput("asyncRstInReady", bus.in_ready, 0);
      tick();
      tick();
      rst_n = 1'b1;
      bus.in_valid = 1'b1;
      repeat (20) tick();
      checkOutput("noSpuriousOutValid", bus.out_valid, 0);
      checkOutput("noAcceptWithoutKey", bus.busy, 0);
      bus.in_valid = 1'b0;
      writeKey(1'b0, 64'd0);
      writeKey(1'b1, 64'd0);
      applyStimulus(64'd0, 1'b0, 1'b0, 1, res, lat);
      checkOutput("vectorAfterReset", res, VEC_ZERO_HOST);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
